elevator_request_scheduler: RTL and testbench
=============================================

# elevator_request_scheduler

Request latching and LOOK-style scheduling core for the four-floor elevator (ground, one, two, three). Latches car calls and hall calls, chooses travel direction, times floor-to-floor travel and door dwell, and drives the floor indicator, motor and door outputs. Sits between the button inputs and the motor/door actuators, replacing ad-hoc floor sequencing in `Top`.

## Interface
- `TRAVEL_CYCLES`, default 8: clock cycles to move one floor (≥2).
- `DOOR_CYCLES`, default 6: clock cycles the door stays open per stop (≥2).

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `floor_sel_in`  in  4  car-call buttons, bit i = floor i, any number of bits may be high
- `up_gnd_in`, `up_one_in`, `up_two_in`  in  1 each  hall up calls, floors 0/1/2
- `down_one_in`, `down_two_in`, `down_three_in`  in  1 each  hall down calls, floors 1/2/3
- `door_hold_in`  in  1  door-hold button, extends dwell while high
- `out_gnd`, `out_one`, `out_two`, `out_three`  out  1 each  one-hot current-floor indicator
- `cur_floor`  out  2  binary current floor
- `move_up`, `move_down`  out  1 each  motor commands
- `door_open`  out  1  door command
- `dir_up`  out  1  current direction preference (1 = up)
- `pending_out`  out  4  bit i = any latched request (car or hall) at floor i

## Operation
- Request registers: `car_req[3:0]`, `hall_up[2:0]`, `hall_dn[3:1]`. Each bit sets on the edge after its input is sampled high; inputs are level, one sampled cycle suffices.
- Clear: on the edge entering DOOR_OPEN at floor f, all request bits for floor f clear. If an input for floor f is high on that same edge, clear wins (car is already there).
- In DOOR_OPEN, inputs for the current floor are not latched; they reload the dwell counter instead.
- "Above" = any pending_out bit > cur_floor; "below" = any bit < cur_floor.
- States:
  - IDLE: door closed, motor off. Priority: pending at cur_floor -> DOOR_OPEN; else requests in `dir_up` direction -> MOVING same direction; else requests opposite -> flip `dir_up`, MOVING; else stay.
  - MOVING: exactly one of `move_up`/`move_down` high per `dir_up`. Travel counter loads TRAVEL_CYCLES-1 on entry, counts down; at 0, `cur_floor` ±1 on that edge and then: pending at new floor -> DOOR_OPEN; else further requests in direction -> stay MOVING (counter reloads); else -> IDLE.
  - DOOR_OPEN: `door_open`=1. Dwell counter loads DOOR_CYCLES-1 on entry; reloads while `door_hold_in` high or a current-floor input is high; at 0 -> IDLE.
- `dir_up` changes only in IDLE, only when no requests remain in current direction.
- Invariants: `move_up` & `move_down` never both 1; `door_open` never with either motor bit; no up move from floor 3, no down move from floor 0.
- Indicator outputs are a decode of registered `cur_floor`, always exactly one-hot.

## Timing
- Reset (sync, one edge with `rst`=1): state IDLE, `cur_floor`=0, `out_gnd`=1, other indicators 0, `move_up`=`move_down`=`door_open`=0, `dir_up`=1, all request bits and `pending_out`=0. Reset mid-move or mid-dwell aborts immediately; car is homed to ground outside this block.
- Input-to-pending latency: 1 cycle. Pending-to-action from IDLE: 1 further cycle.
- One-floor trip: MOVING for exactly TRAVEL_CYCLES cycles; n floors without stop: n×TRAVEL_CYCLES consecutive cycles, motor bit never drops between floors.
- Dwell: `door_open` high exactly DOOR_CYCLES cycles absent extension; after last reload, DOOR_CYCLES more cycles.
- After DOOR_OPEN, at least one IDLE cycle with door closed and motor off before any move.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset with all inputs high -> every output at reset value; 1 cycle after `rst` falls, requests latch.
- Idle at 0, `floor_sel_in`=0100 one cycle -> `pending_out`=0100 next cycle, `move_up` for 16 cycles, `out_two`=1, `door_open` 6 cycles, `pending_out`=0000, back to IDLE.
- At floor 2 idle, `down_one_in` pulse -> `dir_up` flips to 0, `move_down` 8 cycles, stop at 1, door 6 cycles.
- From 0 with `up_two_in` and `down_three_in` and `floor_sel_in`=1000 together -> stops at 2 (door 6 cycles), continues up to 3 (door 6 cycles); never reverses in between.
- Door open at 1, hold `door_hold_in` 10 cycles then drop -> `door_open` stays high until 6 cycles after release; `up_one_in` during dwell does not set `pending_out[1]`.
- Assert `rst` during MOVING between floors 1 and 2 -> next cycle `move_up`=0, `out_gnd`=1, `pending_out`=0000.

Source files
------------

// File: rtl/elevator_request_scheduler.sv
// LOOK-style request scheduler for a four-floor car: latches car/hall calls,
// picks direction, times floor-to-floor travel and door dwell.
module elevator_request_scheduler #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] floor_sel_in,
  input  logic       up_gnd_in,
  input  logic       up_one_in,
  input  logic       up_two_in,
  input  logic       down_one_in,
  input  logic       down_two_in,
  input  logic       down_three_in,
  input  logic       door_hold_in,
  output logic       out_gnd,
  output logic       out_one,
  output logic       out_two,
  output logic       out_three,
  output logic [1:0] cur_floor,
  output logic       move_up,
  output logic       move_down,
  output logic       door_open,
  output logic       dir_up,
  output logic [3:0] pending_out
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVING    = 2'd1,
    S_DOOR_OPEN = 2'd2
  } state_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       cur_floor_q, cur_floor_d;
  logic             dir_up_q, dir_up_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       car_q, car_d, up_q, up_d, dn_q, dn_d;

  logic [3:0] up_in, dn_in, pend, clr_mask, ind;
  logic [1:0] next_floor, clr_floor;
  logic       clr_en, here_in;

  // Hall vectors padded to four floors; the missing calls stay zero forever.
  assign up_in      = {1'b0, up_two_in, up_one_in, up_gnd_in};
  assign dn_in      = {down_three_in, down_two_in, down_one_in, 1'b0};
  assign pend       = car_q | up_q | dn_q;
  assign here_in    = floor_sel_in[cur_floor_q] | up_in[cur_floor_q] | dn_in[cur_floor_q];
  assign next_floor = dir_up_q ? cur_floor_q + 2'd1 : cur_floor_q - 2'd1;

  function automatic logic req_beyond(input logic [3:0] p, input logic [1:0] f,
                                      input logic up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (up ? (i > int'(f)) : (i < int'(f))) r = r | p[i];
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    cnt_d       = cnt_q;
    clr_en      = 1'b0;
    clr_floor   = cur_floor_q;
    case (state_q)
      S_IDLE: begin
        if (pend[cur_floor_q]) begin
          state_d = S_DOOR_OPEN;
          cnt_d   = DOOR_LOAD;
          clr_en  = 1'b1;
        end else if (req_beyond(pend, cur_floor_q, dir_up_q)) begin
          state_d = S_MOVING;
          cnt_d   = TRAVEL_LOAD;
        end else if (req_beyond(pend, cur_floor_q, !dir_up_q)) begin
          dir_up_d = ~dir_up_q;
          state_d  = S_MOVING;
          cnt_d    = TRAVEL_LOAD;
        end
      end
      S_MOVING: begin
        if (cnt_q == '0) begin
          cur_floor_d = next_floor;
          if (pend[next_floor]) begin
            state_d   = S_DOOR_OPEN;
            cnt_d     = DOOR_LOAD;
            clr_en    = 1'b1;
            clr_floor = next_floor;
          end else if (req_beyond(pend, next_floor, dir_up_q)) begin
            cnt_d = TRAVEL_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DOOR_OPEN: begin
        // Calls for the floor we are standing at are served by the open door.
        clr_en = 1'b1;
        if (door_hold_in || here_in) begin
          cnt_d = DOOR_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_floor
    assign clr_mask[gi] = clr_en && (clr_floor == 2'(gi));
    assign car_d[gi]    = (car_q[gi] | floor_sel_in[gi]) & ~clr_mask[gi];
    assign up_d[gi]     = (up_q[gi] | up_in[gi]) & ~clr_mask[gi];
    assign dn_d[gi]     = (dn_q[gi] | dn_in[gi]) & ~clr_mask[gi];
    assign ind[gi]      = (cur_floor_q == 2'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_floor_q <= 2'd0;
      dir_up_q    <= 1'b1;
      cnt_q       <= '0;
      car_q       <= 4'b0000;
      up_q        <= 4'b0000;
      dn_q        <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      cnt_q       <= cnt_d;
      car_q       <= car_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
    end
  end

  assign out_gnd     = ind[0];
  assign out_one     = ind[1];
  assign out_two     = ind[2];
  assign out_three   = ind[3];
  assign cur_floor   = cur_floor_q;
  assign move_up     = (state_q == S_MOVING) && dir_up_q;
  assign move_down   = (state_q == S_MOVING) && !dir_up_q;
  assign door_open   = (state_q == S_DOOR_OPEN);
  assign dir_up      = dir_up_q;
  assign pending_out = pend;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed scenarios with literal
// expectations plus random calls compared every cycle to a behavioural model.
module tb_elevator_request_scheduler;
  localparam int TRAVEL = 8;
  localparam int DOOR   = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fs = 4'b0000;
  logic       ug = 1'b0, uo = 1'b0, ut = 1'b0;
  logic       d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic       hold = 1'b0;

  logic       out_gnd, out_one, out_two, out_three;
  logic [1:0] cur_floor;
  logic       move_up, move_down, door_open, dir_up;
  logic [3:0] pending_out;

  int checks = 0;
  int failures = 0;

  elevator_request_scheduler #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk(clk), .rst(rst), .floor_sel_in(fs),
    .up_gnd_in(ug), .up_one_in(uo), .up_two_in(ut),
    .down_one_in(d1), .down_two_in(d2), .down_three_in(d3),
    .door_hold_in(hold),
    .out_gnd(out_gnd), .out_one(out_one), .out_two(out_two), .out_three(out_three),
    .cur_floor(cur_floor), .move_up(move_up), .move_down(move_down),
    .door_open(door_open), .dir_up(dir_up), .pending_out(pending_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 travelling, 2 door open; m_left counts
  // the cycles still to spend in the current travel leg or dwell.
  int       m_floor = 0;
  int       m_mode  = 0;
  int       m_left  = 0;
  bit       m_dir   = 1'b1;
  bit [3:0] m_car = '0, m_up = '0, m_dn = '0;

  function automatic bit m_wants(input bit [3:0] p, input int f, input bit up);
    bit r;
    r = 1'b0;
    for (int j = 0; j < 4; j++) if ((up && j > f) || (!up && j < f)) r = r | p[j];
    return r;
  endfunction

  task automatic model_step();
    bit [3:0] p, nc, nu, nd, hu, hd;
    int stop;
    hu   = {1'b0, ut, uo, ug};
    hd   = {d3, d2, d1, 1'b0};
    p    = m_car | m_up | m_dn;
    stop = -1;
    nc   = m_car | fs;
    nu   = m_up | hu;
    nd   = m_dn | hd;
    case (m_mode)
      0: begin
        if (p[m_floor]) begin
          m_mode = 2; m_left = DOOR; stop = m_floor;
        end else if (m_wants(p, m_floor, m_dir)) begin
          m_mode = 1; m_left = TRAVEL;
        end else if (m_wants(p, m_floor, !m_dir)) begin
          m_dir = !m_dir; m_mode = 1; m_left = TRAVEL;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_dir ? 1 : -1;
          if (p[m_floor]) begin
            m_mode = 2; m_left = DOOR; stop = m_floor;
          end else if (m_wants(p, m_floor, m_dir)) m_left = TRAVEL;
          else m_mode = 0;
        end
      end
      default: begin
        stop = m_floor;
        if (hold || fs[m_floor] || hu[m_floor] || hd[m_floor]) m_left = DOOR;
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
    endcase
    if (stop >= 0) begin
      nc[stop] = 1'b0; nu[stop] = 1'b0; nd[stop] = 1'b0;
    end
    m_car = nc; m_up = nu; m_dn = nd;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_floor = 0; m_mode = 0; m_left = 0; m_dir = 1'b1;
      m_car = '0; m_up = '0; m_dn = '0;
    end else begin
      model_step();
    end
  end

  function automatic logic [13:0] exp_vec();
    return {m_floor == 3, m_floor == 2, m_floor == 1, m_floor == 0, 2'(m_floor),
            m_mode == 1 && m_dir, m_mode == 1 && !m_dir, m_mode == 2, m_dir,
            m_car | m_up | m_dn};
  endfunction

  logic [13:0] dut_vec;
  assign dut_vec = {out_three, out_two, out_one, out_gnd, cur_floor,
                    move_up, move_down, door_open, dir_up, pending_out};

  always @(negedge clk) begin
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL cycle_compare t=%0t: got %b required %b", $time, dut_vec, exp_vec());
    end
    checks++;
    if ((move_up && move_down) || (door_open && (move_up || move_down)) ||
        ({out_three, out_two, out_one, out_gnd} != (4'b0001 << cur_floor))) begin
      failures++;
      $display("FAIL invariant t=%0t: got outputs %b", $time, dut_vec);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("check %s got %0d", name, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return move_up;
      1: return move_down;
      default: return door_open;
    endcase
  endfunction

  // Waits (bounded) for the chosen output to rise, then counts its high cycles.
  task automatic measure(input int which, input string name, input int exp_len);
    int w, n;
    w = 0;
    while (!sig(which) && w < 200) begin
      tick(1); w++;
    end
    if (!sig(which)) begin
      chk({name, "_start"}, 0, 1);
      return;
    end
    n = 0;
    while (sig(which) && n < 200) begin
      n++; tick(1);
    end
    chk(name, n, exp_len);
  endtask

  initial begin
    // Reset with every input high.
    fs = 4'b1111; ug = 1; uo = 1; ut = 1; d1 = 1; d2 = 1; d3 = 1; hold = 1;
    rst = 1'b1;
    tick(2);
    chk("reset_outputs", int'(dut_vec), int'(14'b0001_00_0001_0000));
    rst = 1'b0;
    tick(1);
    chk("latch_after_reset", int'(pending_out), 4'b1111);

    fs = 4'b0000; ug = 0; uo = 0; ut = 0; d1 = 0; d2 = 0; d3 = 0; hold = 0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);

    // Car call to floor 2 from ground.
    fs = 4'b0100; tick(1); fs = 4'b0000;
    chk("pending_car2", int'(pending_out), 4'b0100);
    measure(0, "up_0_to_2", 2 * TRAVEL);
    chk("arrive_floor2", int'(out_two), 1);
    measure(2, "dwell_floor2", DOOR);
    chk("cleared_floor2", int'(pending_out), 0);

    // Hall down call at 1 from floor 2 flips direction.
    d1 = 1'b1; tick(1); d1 = 1'b0;
    tick(1);
    chk("dir_flip_down", int'({dir_up, move_down}), 2'b01);
    measure(1, "down_2_to_1", TRAVEL);
    chk("arrive_floor1", int'(cur_floor), 1);
    measure(2, "dwell_floor1", DOOR);

    // Home to ground, then mixed calls upward.
    fs = 4'b0001; tick(1); fs = 4'b0000;
    measure(1, "down_1_to_0", TRAVEL);
    measure(2, "dwell_floor0", DOOR);
    ut = 1'b1; d3 = 1'b1; fs = 4'b1000; tick(1);
    ut = 1'b0; d3 = 1'b0; fs = 4'b0000;
    measure(0, "up_0_to_2_mixed", 2 * TRAVEL);
    chk("stop_at_2", int'(cur_floor), 2);
    measure(2, "dwell_mixed_2", DOOR);
    chk("still_pending_3", int'(pending_out), 4'b1000);
    measure(0, "up_2_to_3", TRAVEL);
    chk("stop_at_3", int'(cur_floor), 3);
    measure(2, "dwell_floor3", DOOR);

    // Door hold at floor 1 with a same-floor hall call during dwell.
    fs = 4'b0010; tick(1); fs = 4'b0000;
    measure(1, "down_3_to_1", 2 * TRAVEL);
    hold = 1'b1; uo = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("hold_no_latch", int'(pending_out[1]), 0);
    end
    hold = 1'b0; uo = 1'b0;
    measure(2, "dwell_after_hold", DOOR);

    // Reset in the middle of a 1->2 leg.
    fs = 4'b1000; tick(1); fs = 4'b0000;
    tick(4);
    chk("moving_before_reset", int'(move_up), 1);
    rst = 1'b1; tick(1);
    chk("reset_mid_move", int'({move_up, out_gnd, pending_out}), 6'b010000);
    rst = 1'b0; tick(1);

    // Random calls, holds and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) fs[b] = ($urandom_range(0, 24) == 0);
      ug = ($urandom_range(0, 29) == 0);
      uo = ($urandom_range(0, 29) == 0);
      ut = ($urandom_range(0, 29) == 0);
      d1 = ($urandom_range(0, 29) == 0);
      d2 = ($urandom_range(0, 29) == 0);
      d3 = ($urandom_range(0, 29) == 0);
      hold = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
